// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between the fetch stage (F)
// and the memory stage (M). Only one bus transaction is outstanding at a time, and M
// has fixed priority over F. A fetch response that a branch redirect has killed is
// discarded. A wait-cycle counter aborts a hung transaction and sets a sticky error.
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   F_req/F_addr/F_kill          fetch request, address, redirect kill
//   F_valid/F_rdata/F_stall_mem  fetch completion pulse, data, stall
//   M_req/M_we/M_addr/M_wdata/M_wstrb  load/store request
//   M_done/M_rdata/M_stall_mem   memory completion pulse, load data, stall
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb/bus_gnt  request channel
//   bus_rvalid/bus_rdata         response channel
//   bus_err                      sticky timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  // Fetch port
  input  logic                F_req,
  input  logic [ADDR_W-1:0]   F_addr,
  input  logic                F_kill,
  output logic                F_valid,
  output logic [DATA_W-1:0]   F_rdata,
  output logic                F_stall_mem,
  // Memory-stage port
  input  logic                M_req,
  input  logic                M_we,
  input  logic [ADDR_W-1:0]   M_addr,
  input  logic [DATA_W-1:0]   M_wdata,
  input  logic [DATA_W/8-1:0] M_wstrb,
  output logic                M_done,
  output logic [DATA_W-1:0]   M_rdata,
  output logic                M_stall_mem,
  // Bus
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  localparam int unsigned StrbW = DATA_W / 8;
  // The counter only has to reach TIMEOUT-1 before the state is left.
  localparam int unsigned CntW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StDReq, StDRsp, StFReq, StFRsp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                kill_q, kill_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [StrbW-1:0]    bus_wstrb_q, bus_wstrb_d;
  logic                f_valid_q, f_valid_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic                m_done_q, m_done_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
  logic                bus_err_q, bus_err_d;

  logic timeout, d_abort, f_abort, f_discard, idle_free;

  // A completion pulse means the finished request is still being presented,
  // so no new transaction may start in that cycle.
  assign idle_free = ~m_done_q & ~f_valid_q;
  assign timeout   = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT - 1));
  assign d_abort   = timeout && (((state_q == StDReq) && !bus_gnt) ||
                                 ((state_q == StDRsp) && !bus_rvalid));
  assign f_abort   = timeout && (((state_q == StFReq) && !bus_gnt) ||
                                 ((state_q == StFRsp) && !bus_rvalid));
  // A kill in the same cycle as the response still discards it.
  assign f_discard = kill_q | F_kill;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (idle_free) begin
          if (M_req) begin
            state_d = StDReq;
          end else if (F_req && !F_kill) begin
            state_d = StFReq;
          end
        end
      end
      StDReq: begin
        if (bus_gnt)      state_d = StDRsp;
        else if (d_abort) state_d = StIdle;
      end
      StDRsp: begin
        if (bus_rvalid || d_abort) state_d = StIdle;
      end
      StFReq: begin
        if (bus_gnt)      state_d = StFRsp;
        else if (f_abort) state_d = StIdle;
      end
      StFRsp: begin
        if (bus_rvalid || f_abort) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus_req = (state_q == StDReq) || (state_q == StFReq);
  end

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    f_valid_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    m_done_d    = 1'b0;
    m_rdata_d   = m_rdata_q;
    bus_err_d   = bus_err_q;

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q != StIdle) begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (state_q == StIdle && state_d == StDReq) begin
      bus_we_d    = M_we;
      bus_addr_d  = M_addr;
      bus_wdata_d = M_wdata;
      bus_wstrb_d = M_wstrb;
    end else if (state_q == StIdle && state_d == StFReq) begin
      bus_we_d    = 1'b0;
      bus_addr_d  = F_addr;
      bus_wdata_d = '0;
      bus_wstrb_d = '0;
    end

    if ((state_q == StFReq || state_q == StFRsp) && F_kill) begin
      kill_d = 1'b1;
    end

    if (state_q == StDRsp && bus_rvalid) begin
      m_done_d = 1'b1;
      if (!bus_we_q) m_rdata_d = bus_rdata;
    end else if (d_abort) begin
      m_done_d  = 1'b1;
      m_rdata_d = '0;
      bus_err_d = 1'b1;
    end

    if (state_q == StFRsp && bus_rvalid) begin
      if (!f_discard) begin
        f_valid_d = 1'b1;
        f_rdata_d = bus_rdata;
      end
    end else if (f_abort) begin
      bus_err_d = 1'b1;
      if (!f_discard) begin
        f_valid_d = 1'b1;
        f_rdata_d = '0;
      end
    end

    if (state_d == StIdle) kill_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      f_valid_q   <= 1'b0;
      f_rdata_q   <= '0;
      m_done_q    <= 1'b0;
      m_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      f_valid_q   <= f_valid_d;
      f_rdata_q   <= f_rdata_d;
      m_done_q    <= m_done_d;
      m_rdata_q   <= m_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_wstrb   = bus_wstrb_q;
  assign bus_err     = bus_err_q;
  assign F_valid     = f_valid_q;
  assign F_rdata     = f_rdata_q;
  assign M_done      = m_done_q;
  assign M_rdata     = m_rdata_q;
  assign F_stall_mem = F_req & ~f_valid_q;
  assign M_stall_mem = M_req & ~m_done_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory bus between the instruction-fetch stage (F) and the memory stage (M) of the 5-stage pipeline. It issues one bus transaction at a time with fixed priority to M and discards fetch responses killed by a branch redirect. It also supplies `F_stall_mem` and `M_stall_mem`, which the pipeline ORs into the hazard stalls. A wait-cycle counter aborts hung transactions and raises a sticky error.

## Interface
- `ADDR_W`, 32, bus and request address width
- `DATA_W`, 32, data width; `DATA_W/8` byte strobes
- `TIMEOUT`, 255, max cycles in any REQ/RSP state before abort (≥2)
- `clk  in  1  clock; all logic on rising edge`
- `rst_n  in  1  reset; synchronous, active-low`
- `F_req  in  1  fetch wants instruction at F_addr`
- `F_addr  in  ADDR_W  fetch address`
- `F_kill  in  1  redirect (E_pcsrc); discard any fetch in flight`
- `F_valid  out  1  one-cycle pulse: F_rdata valid`
- `F_rdata  out  DATA_W  registered instruction`
- `F_stall_mem  out  1  freeze F/D: F_req & ~F_valid`
- `M_req  in  1  load/store in M`
- `M_we  in  1  1=store`
- `M_addr  in  ADDR_W`, `M_wdata  in  DATA_W`, `M_wstrb  in  DATA_W/8  store operands`
- `M_done  out  1  one-cycle pulse: M access complete`
- `M_rdata  out  DATA_W  registered load data`
- `M_stall_mem  out  1  freeze whole pipe: M_req & ~M_done`
- `bus_req  out  1`, `bus_we  out  1`, `bus_addr  out  ADDR_W`, `bus_wdata  out  DATA_W`, `bus_wstrb  out  DATA_W/8  request channel`
- `bus_gnt  in  1  request accepted when bus_req & bus_gnt`
- `bus_rvalid  in  1  response (read data or write ack)`
- `bus_rdata  in  DATA_W`
- `bus_err  out  1  sticky timeout flag`

## Operation
- FSM states: IDLE, D_REQ, D_RSP, F_REQ, F_RSP.
- IDLE: no issue if `M_done` or `F_valid` is high this cycle (the completing request is still presented). Otherwise `M_req` → D_REQ; else `F_req & ~F_kill` → F_REQ. M always wins a tie.
- On issue, latch the address/we/wdata/wstrb into bus registers. Fetch: `bus_we=0`, `bus_wstrb=0`.
- `bus_req` = (state is D_REQ or F_REQ). It is held with stable payload until `bus_gnt` and is never retracted, including on `F_kill`.
- REQ state & `bus_gnt` → matching RSP state; `bus_req` drops next cycle.
- D_RSP & `bus_rvalid`:
  - `M_rdata` ← `bus_rdata` (loads only; stores leave it unchanged).
  - `M_done`=1 next cycle.
  - → IDLE.
- F_RSP & `bus_rvalid`:
  - If the kill flag is clear: `F_rdata` ← `bus_rdata`, `F_valid`=1 next cycle.
  - Either way → IDLE.
- Kill flag: set by `F_kill` while in F_REQ or F_RSP, or on the cycle the fetch issues. Cleared on entry to IDLE. A killed fetch completes on the bus silently.
- `bus_rvalid` in IDLE/REQ states is ignored, including stale responses after reset.
- Timeout:
  - The counter clears on every state change and increments in REQ/RSP states.
  - Reaching `TIMEOUT` → IDLE, `bus_err`=1 (sticky), and a pulse of `M_done` or `F_valid` (if not killed) with rdata forced to 0, so the pipe cannot hang.
- Reset values: state IDLE; `bus_req`, `bus_we`, `F_valid`, `M_done`, `bus_err`, kill flag = 0; all data/address registers = 0.
- Reset mid-transaction: abandon immediately; no pulse is generated.

## Timing
- Minimum M latency: `M_req` cycle t → `bus_req` t+1 (gnt same cycle) → `bus_rvalid` t+2 → `M_done` t+3. Same for fetch.
- One idle cycle follows each completion (the no-issue rule). Sustained throughput is one access per 4 cycles at zero bus wait.
- `F_stall_mem` and `M_stall_mem` are combinational from registered `F_valid`/`M_done` and the live requests.
- An M request arriving while a fetch is in F_REQ/F_RSP waits for that fetch to finish; no pre-emption.
- `F_kill` and `bus_rvalid` in the same F_RSP cycle: the response is discarded.
- Timeout fires exactly `TIMEOUT` cycles after entering the waiting state.

## Test plan
- Load with zero bus wait: `M_req=1`, `M_we=0`, `M_addr=0x100`, gnt immediate, rvalid next cycle with `0xDEADBEEF` → `bus_addr=0x100` at t+1, `M_done` at t+3, `M_rdata=0xDEADBEEF`, `M_stall_mem` high t..t+2.
- Simultaneous requests: `F_req` (`F_addr=0x40`) and store (`M_addr=0x200`, `M_wdata=0x12345678`, `M_wstrb=0xF`) both at t → store issued first with `bus_we=1`; fetch `bus_req` only after the `M_done` cycle plus one idle cycle.
- Grant backpressure: `bus_gnt` low for 5 cycles → `bus_req` and payload stable throughout; FSM enters RSP only on the gnt cycle.
- Killed fetch: issue fetch at 0x80, pulse `F_kill` in F_RSP, rvalid with `0x00000013` → no `F_valid`, `F_rdata` unchanged, FSM in IDLE next cycle.
- Timeout with `TIMEOUT=8`, load granted, no rvalid → abort 8 cycles into D_RSP; `M_done`=1, `M_rdata=0`, `bus_err`=1 and it stays 1 through later good transfers until `rst_n=0`.
- Reset in D_RSP, then rvalid arrives → state IDLE, all outputs at reset values, stale rvalid ignored, no `M_done`.
